// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared states, defaults and helpers for the word scan controller
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_DEF = 4'b0101;
  localparam logic [2:0] LEN_DEF = 3'd3;
  localparam logic       OVL_DEF = 1'b1;
  localparam logic [2:0] LEN_MIN = 3'd2;

  // A pattern length is usable when it fits between the minimum and the window size
  function automatic logic len_legal(input logic [2:0] len, input logic [2:0] len_max);
    return (len >= LEN_MIN) && (len <= len_max);
  endfunction

endpackage

// File: rtl/seq_matcher.sv
// rtl/seq_matcher.sv - bit-serial pattern window with fill tracking and hit decode
module seq_matcher
  import seq_scan_pkg::*;
#(
  parameter int PAT_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               bit_vld,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [2:0]         len,
  input  logic               ovl,
  output logic               hit
);

  logic [PAT_MAX-1:0] win_q, win_d, win_shift, mask;
  logic [2:0]         fill_q, fill_d, fill_inc;
  logic               match;

  // Evaluate the window as it will look with the incoming bit, so the hit is counted on the same edge
  always_comb begin
    win_shift = {win_q[PAT_MAX-2:0], bit_in};
    fill_inc  = (fill_q == 3'(PAT_MAX)) ? fill_q : fill_q + 3'd1;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (3'(i) < len);
    end
    match  = (fill_inc >= len) && ((win_shift & mask) == (pat & mask));
    hit    = bit_vld && match;
    win_d  = win_q;
    fill_d = fill_q;
    if (bit_vld) begin
      if (hit && !ovl) begin
        win_d  = '0;
        fill_d = '0;
      end else begin
        win_d  = win_shift;
        fill_d = fill_inc;
      end
    end
  end

  // Window state; cleared whenever the controller is between words
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word handshake, MSB-first serialisation and hit counting around seq_matcher
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = $clog2(DW + 1),
  parameter int PAT_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [2:0]         cfg_len,
  input  logic               cfg_ovl,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_count,
  output logic               out_hit,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [DW-1:0]      shreg_q, shreg_d;
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [2:0]         len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic               cfg_ok;
  logic               m_hit;

  assign cfg_ok = cfg_we && (state_q == IDLE) && len_legal(cfg_len, 3'(PAT_MAX));

  seq_matcher #(
    .PAT_MAX(PAT_MAX)
  ) u_matcher (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .bit_vld(state_q == SHIFT),
    .bit_in (shreg_q[DW-1]),
    .pat    (pat_q),
    .len    (len_q),
    .ovl    (ovl_q),
    .hit    (m_hit)
  );

  // Next-state: config writes, word accept, serial shifting with hit counting, result handoff
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    err_d    = cfg_we && !cfg_ok;
    if (cfg_ok) begin
      pat_d = cfg_pat;
      len_d = cfg_len;
      ovl_d = cfg_ovl;
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d  = in_data;
          bitcnt_d = '0;
          cnt_d    = '0;
          hit_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + CW'(1);
        if (m_hit) begin
          cnt_d = cnt_q + CW'(1);
        end
        hit_d = (cnt_d != '0);
        if (bitcnt_q == CW'(DW - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with configuration defaults on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      pat_q    <= PAT_MAX'(PAT_DEF);
      len_q    <= LEN_DEF;
      ovl_q    <= OVL_DEF;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = cnt_q;
  assign out_hit   = hit_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int PAT_MAX = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pat;
  logic [2:0]         cfg_len;
  logic               cfg_ovl;
  logic               cfg_err;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      out_count;
  logic               out_hit;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_scan_ctrl #(
    .DW(DW),
    .CW(CW),
    .PAT_MAX(PAT_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_pat  (cfg_pat),
    .cfg_len  (cfg_len),
    .cfg_ovl  (cfg_ovl),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_hit  (out_hit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word, optionally poke a config write during SHIFT, and check timing and result
  task automatic run_word(input string tag, input logic [DW-1:0] d, input int exp_cnt, input bit inj);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    if (inj) begin
      cfg_we  = 1'b1;
      cfg_pat = 4'b0101;
      cfg_len = 3'd3;
      cfg_ovl = 1'b1;
    end
    for (int i = 1; i <= DW; i++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (inj && i == 1) check_eq({tag, "_err_pulse"}, cfg_err, 1);
      if (inj && i == 2) check_eq({tag, "_err_drop"}, cfg_err, 0);
      if (i == DW - 1) check_eq({tag, "_early_valid"}, out_valid, 0);
    end
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_count"}, out_count, exp_cnt);
    check_eq({tag, "_hit"}, out_hit, (exp_cnt != 0) ? 1 : 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_rel_valid"}, out_valid, 0);
    check_eq({tag, "_rel_ready"}, in_ready, 1);
  endtask

  task automatic cfg_write(input string tag, input logic [3:0] p, input logic [2:0] l,
                           input logic o, input logic exp_err);
    cfg_we  = 1'b1;
    cfg_pat = p;
    cfg_len = l;
    cfg_ovl = o;
    @(negedge clk);
    cfg_we = 1'b0;
    check_eq({tag, "_err"}, cfg_err, exp_err);
    @(negedge clk);
    check_eq({tag, "_err_after"}, cfg_err, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_pat   = '0;
    cfg_len   = '0;
    cfg_ovl   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy_after", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_count", out_count, 0);
    check_eq("rst_out_hit", out_hit, 0);
    check_eq("rst_cfg_err", cfg_err, 0);

    // default 101 overlapping on 1010_1010: hits at bits 3,5,7
    run_word("def_aa", 8'b1010_1010, 3, 1'b0);
    release_result("def_aa");

    // 101 non-overlapping: hits at bits 3 and 7
    cfg_write("cfg_novl", 4'b0101, 3'd3, 1'b0, 1'b0);
    run_word("novl_aa", 8'b1010_1010, 2, 1'b0);
    release_result("novl_aa");

    // 1011 overlapping on 1011_0110: hits at bits 4 and 7
    cfg_write("cfg_1011", 4'b1011, 3'd4, 1'b1, 1'b0);
    run_word("p1011_b6", 8'b1011_0110, 2, 1'b0);
    release_result("p1011_b6");
    run_word("p1011_00", 8'h00, 0, 1'b0);
    release_result("p1011_00");

    // backpressure: result held for 5 cycles
    run_word("bp_b6", 8'b1011_0110, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_count", out_count, 2);
      check_eq("bp_in_ready", in_ready, 0);
    end
    release_result("bp_b6");
    check_eq("bp_idle_busy", busy, 0);

    // config write during SHIFT is rejected; 1011 never occurs in 1010_1010
    run_word("inj_aa", 8'b1010_1010, 0, 1'b1);
    release_result("inj_aa");

    // illegal length rejected, config stays 1011/4
    cfg_write("cfg_len5", 4'b0101, 3'd5, 1'b1, 1'b1);
    run_word("len5_aa", 8'b1010_1010, 0, 1'b0);
    release_result("len5_aa");

    // config and word in the same IDLE cycle: word uses 101 non-overlapping
    cfg_we  = 1'b1;
    cfg_pat = 4'b0101;
    cfg_len = 3'd3;
    cfg_ovl = 1'b0;
    run_word("same_aa", 8'b1010_1010, 2, 1'b0);
    check_eq("same_err", cfg_err, 0);
    release_result("same_aa");

    // reset in the middle of SHIFT
    in_valid = 1'b1;
    in_data  = 8'b1010_1010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_valid", out_valid, 0);
    check_eq("mid_count", out_count, 0);
    check_eq("mid_in_ready_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("mid_in_ready", in_ready, 1);
    @(negedge clk);
    // defaults restored: 101 overlapping gives 3, not 2
    run_word("post_rst_aa", 8'b1010_1010, 3, 1'b0);
    release_result("post_rst_aa");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
